rob_ctrl: RTL and testbench

Reorder-buffer controller: issues 4-bit tags to in-order requests, accepts out-of-order responses carrying those tags, writes response data into the 16-entry reorder storage, and drains entries strictly in allocation order over a valid/ready output port. Sits directly upstream and downstream of the 16x8 reorder storage. It drives the storage write port and read address and consumes the storage's combinational read data. Entry completion is tracked internally; the storage's own valid flags are not used.

---
 rtl/rob_ctrl_if.sv | 44 ++++
 rtl/rob_ctrl.sv | 80 ++++++++
 tb/tb_rob_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_ctrl_if.sv
// Reorder-buffer controller port bundle: allocation, response, storage and drain signals.
// Combinational pass-through only; no latency of its own.
// Backpressure is carried by out_ready_i (drain) and alloc_gnt_o (allocation).
interface rob_ctrl_if #(
    parameter int DW = 8
);
    // allocation
    logic          alloc_req_i;
    logic          alloc_gnt_o;
    logic [3:0]    alloc_tag_o;
    // out-of-order responses
    logic          rsp_vld_i;
    logic [3:0]    rsp_tag_i;
    logic [DW-1:0] rsp_data_i;
    // reorder storage
    logic          mem_we_o;
    logic [3:0]    mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_raddr_o;
    logic [DW-1:0] mem_rdata_i;
    // in-order drain
    logic          out_vld_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    // status
    logic [4:0]    count_o;
    logic          full_o;
    logic          empty_o;
    logic          err_o;

    // controller side
    modport slave (
        input  alloc_req_i, rsp_vld_i, rsp_tag_i, rsp_data_i, mem_rdata_i, out_ready_i,
        output alloc_gnt_o, alloc_tag_o, mem_we_o, mem_waddr_o, mem_wdata_o, mem_raddr_o,
               out_vld_o, out_data_o, count_o, full_o, empty_o, err_o
    );

    // requester / responder / consumer / storage side
    modport master (
        output alloc_req_i, rsp_vld_i, rsp_tag_i, rsp_data_i, mem_rdata_i, out_ready_i,
        input  alloc_gnt_o, alloc_tag_o, mem_we_o, mem_waddr_o, mem_wdata_o, mem_raddr_o,
               out_vld_o, out_data_o, count_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: grants tags in order, accepts out-of-order responses, drains in order.
// Grant and storage write are combinational; an accepted head response drains the next cycle.
// Drain holds out_vld_o/out_data_o while out_ready_i is low; full blocks allocation, no bypass.
//
// Ports: clk, rst_n (async active-low), bus (rob_ctrl_if.slave) carrying the allocation,
// response, storage write/read, drain and status signals.
module rob_ctrl #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rob_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] done_q;
    logic             err_q;

    logic             full;
    logic             empty;
    logic             gnt;
    logic             rsp_acc;
    logic             out_vld;
    logic             retire;
    logic [DW-1:0]    rd_data;

    assign full    = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign empty   = (head == tail);
    assign gnt     = bus.alloc_req_i && !full;
    // Only a tag that is outstanding and not yet answered may write storage.
    assign rsp_acc = bus.rsp_vld_i && alloc_q[bus.rsp_tag_i] && !done_q[bus.rsp_tag_i];
    assign out_vld = !empty && done_q[head[AW-1:0]];
    assign retire  = out_vld && bus.out_ready_i;
    assign rd_data = bus.mem_rdata_i;

    assign bus.alloc_gnt_o = gnt;
    assign bus.alloc_tag_o = tail[AW-1:0];
    assign bus.mem_we_o    = rsp_acc;
    assign bus.mem_waddr_o = bus.rsp_tag_i;
    assign bus.mem_wdata_o = bus.rsp_data_i;
    assign bus.mem_raddr_o = head[AW-1:0];
    assign bus.out_vld_o   = out_vld;
    assign bus.out_data_o  = rd_data;
    assign bus.count_o     = tail - head;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.err_o       = err_q;

    // The set and clear indices never collide: allocation at tail==head index
    // needs full (grant blocked), and a response to the head tag cannot be
    // accepted in a cycle where the head retires because it is already done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.rsp_vld_i && !rsp_acc;
            if (gnt) begin
                alloc_q[tail[AW-1:0]] <= 1'b1;
                tail                  <= tail + 1'b1;
            end
            if (rsp_acc) begin
                done_q[bus.rsp_tag_i] <= 1'b1;
            end
            if (retire) begin
                alloc_q[head[AW-1:0]] <= 1'b0;
                done_q[head[AW-1:0]]  <= 1'b0;
                head                  <= head + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl against a queue-based reorder model.
// One cycle per step; outputs sampled mid-cycle, model advanced on the clock edge.
// Consumer backpressure driven directly via out_ready_i.
module tb_rob_ctrl;
    logic clk;
    logic rst_n;

    rob_ctrl_if #(.DW(8)) bus ();

    rob_ctrl #(.DEPTH(16), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x8 reorder storage: synchronous write, combinational read
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_waddr_o] <= bus.mem_wdata_o;
    end
    assign bus.mem_rdata_i = mem[bus.mem_raddr_o];

    // ---------------- reference model ----------------
    int         q[$];      // outstanding tags, allocation order
    bit         got[16];   // response seen for tag
    logic [7:0] md[16];    // data delivered for tag
    int         nt;        // total allocations since reset
    bit         exp_err;

    int n_chk;
    int n_err;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit outstanding(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) got[i] = 1'b0;
        nt      = 0;
        exp_err = 1'b0;
    endtask

    // One cycle: drive, check mid-cycle, advance model at the edge.
    task automatic step(input bit req, input bit rv, input logic [3:0] rt,
                        input logic [7:0] rd, input bit rdy);
        bit legal, e_vld, e_gnt;
        int head_t;
        bus.alloc_req_i = req;
        bus.rsp_vld_i   = rv;
        bus.rsp_tag_i   = rt;
        bus.rsp_data_i  = rd;
        bus.out_ready_i = rdy;
        #3;
        legal  = rv && outstanding(rt) && !got[rt];
        e_gnt  = req && (q.size() < 16);
        e_vld  = (q.size() > 0) && got[q[0]];
        head_t = (nt - q.size()) % 16;
        check_val("count", bus.count_o, q.size());
        check_val("full", bus.full_o, q.size() == 16);
        check_val("empty", bus.empty_o, q.size() == 0);
        check_val("gnt", bus.alloc_gnt_o, e_gnt);
        if (e_gnt) check_val("tag", bus.alloc_tag_o, nt % 16);
        check_val("we", bus.mem_we_o, legal);
        if (rv) begin
            check_val("waddr", bus.mem_waddr_o, rt);
            check_val("wdata", bus.mem_wdata_o, rd);
        end
        check_val("raddr", bus.mem_raddr_o, head_t);
        check_val("vld", bus.out_vld_o, e_vld);
        if (e_vld) check_val("data", bus.out_data_o, md[q[0]]);
        check_val("err", bus.err_o, exp_err);
        @(posedge clk);
        if (e_vld && rdy) begin
            got[q[0]] = 1'b0;
            void'(q.pop_front());
        end
        if (e_gnt) begin
            q.push_back(nt % 16);
            nt++;
        end
        if (legal) begin
            got[rt] = 1'b1;
            md[rt]  = rd;
        end
        exp_err = rv && !legal;
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_req_i = 1'b0;
        bus.rsp_vld_i   = 1'b0;
        bus.rsp_tag_i   = '0;
        bus.rsp_data_i  = '0;
        bus.out_ready_i = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases away from the edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check_val("rst_vld", bus.out_vld_o, 0);
        check_val("rst_count", bus.count_o, 0);
        check_val("rst_empty", bus.empty_o, 1);
        check_val("rst_full", bus.full_o, 0);
        check_val("rst_err", bus.err_o, 0);
        check_val("rst_raddr", bus.mem_raddr_o, 0);
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Random response: mostly a pending tag, occasionally an arbitrary (possibly illegal) one.
    task automatic rand_rsp(output bit rv, output logic [3:0] rt);
        int pend[$];
        foreach (q[i]) if (!got[q[i]]) pend.push_back(q[i]);
        rv = 1'b0;
        rt = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) rv = 1'b1;
        else if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            rv = 1'b1;
            rt = 4'(pend[$urandom_range(0, pend.size() - 1)]);
        end
    endtask

    initial begin
        bit         rv;
        logic [3:0] rt;
        logic [7:0] held;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        model_clear();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        do_reset();

        // fill all 16 entries, then one more request must be refused
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 1);
        check_val("fill_count", bus.count_o, 16);
        check_val("fill_full", bus.full_o, 1);
        step(1, 0, 0, 0, 1);

        // out-of-order completion 2,0,3,1
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        step(0, 1, 4'd2, 8'hA2, 1);
        step(0, 1, 4'd0, 8'hA0, 1);
        step(0, 1, 4'd3, 8'hA3, 1);
        step(0, 1, 4'd1, 8'hA1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        check_val("ooo_empty", bus.empty_o, 1);

        // back-pressure, then illegal and duplicate responses while held
        do_reset();
        step(1, 0, 0, 0, 0);
        step(0, 1, 4'd0, 8'h5C, 0);
        #3 held = bus.out_data_o;
        #1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 4'd7, 8'h77, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 4'd0, 8'hEE, 0);
        step(0, 0, 0, 0, 0);
        #3 check_val("dup_hold", bus.out_data_o, held);
        #1;
        step(0, 0, 0, 0, 1);

        // continuous random traffic well past tag wrap-around
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rand_rsp(rv, rt);
            step($urandom_range(0, 4) != 0, rv, rt, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        check_val("wrapped", nt > 32, 1);

        // reset with several entries outstanding
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 4'd0, 8'h11, 0);
        do_reset();
        step(1, 0, 0, 0, 1);
        check_val("post_rst_q0", q[0], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
